// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_reg
//  Brief    : One-cycle pipeline register with valid/ready handshake, bubble
//             insertion on stall and flush. Define PIPE_SKID_EN to add a skid
//             entry that lets in_ready come straight from a flop.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int                DATA_W  = 160,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count_out
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic              w_accept;
    logic              w_pop;
    logic              w_main_ld;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              w_skid_ld;
    logic              w_main_from_skid;

    assign in_ready = r_in_ready;
`else
    // Pass-through ready: the single entry may be replaced in the cycle it pops.
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = out_valid ? r_main : NOP_VAL;
    assign count_out = r_state;

    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
`ifdef PIPE_SKID_EN
        w_skid_ld        = 1'b0;
        w_main_from_skid = 1'b0;
`endif
        if (flush_in) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_ONE;
                        w_main_ld   = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_ld = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
`ifdef PIPE_SKID_EN
                    else if (w_accept) begin
                        w_state_nxt = S_TWO;
                        w_skid_ld   = 1'b1;
                    end
`endif
                end
`ifdef PIPE_SKID_EN
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt      = S_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_EMPTY;
            r_main  <= NOP_VAL;
        end else begin
            r_state <= w_state_nxt;
            if (flush_in) begin
                r_main <= NOP_VAL;
            end
`ifdef PIPE_SKID_EN
            else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
`endif
            else if (w_main_ld) begin
                r_main <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_skid     <= NOP_VAL;
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_nxt != S_TWO);
            if (flush_in || w_main_from_skid) begin
                r_skid <= NOP_VAL;
            end else if (w_skid_ld) begin
                r_skid <= in_data;
            end
        end
    end
`endif

endmodule
`default_nettype wire
